// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus sequential MUL/DIV/MOD
// behind a start/busy/done handshake, with registered result, high result and Z/C/N flags.
module alu_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUS_WIDTH    = 8,
    parameter int OPCODE_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   value1,
    input  logic [DATA_WIDTH-1:0]   value2,
    input  logic [BUS_WIDTH-1:0]    addr1,
    input  logic [BUS_WIDTH-1:0]    addr2,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [DATA_WIDTH-1:0]   result_hi,
    output logic                    flag_z,
    output logic                    flag_c,
    output logic                    flag_n,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    finish
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = (DW > 2) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_XOR = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_NOR = 4'd5,  OP_NAND = 4'd6, OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_GT = 4'd10,  OP_EQ   = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12, OP_DIV = 4'd13, OP_MOD = 4'd14, OP_HALT = 4'd15;

    typedef enum logic [0:0] {S_IDLE, S_MULDIV} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [3:0]      op_q, op_d;
    logic [DW-1:0]   result_q, result_d, result_hi_q, result_hi_d;
    logic            z_q, z_d, c_q, c_d, n_q, n_d;
    logic            done_q, done_d, err_q, err_d;

    logic [DW-1:0]   addr1_ext, addr2_ext, op1, op2;
    logic [3:0]      op;

    // Address operands are zero-extended or truncated to the datapath width.
    if (BUS_WIDTH >= DW) begin : g_trunc
        assign addr1_ext = addr1[DW-1:0];
        assign addr2_ext = addr2[DW-1:0];
    end else begin : g_zext
        assign addr1_ext = {{(DW-BUS_WIDTH){1'b0}}, addr1};
        assign addr2_ext = {{(DW-BUS_WIDTH){1'b0}}, addr2};
    end

    assign op1    = opcode[0] ? addr1_ext : value1;
    assign op2    = opcode[1] ? addr2_ext : value2;
    assign op     = opcode[5:2];
    assign finish = &opcode;

    logic [DW:0]     sum_w, diff_w;
    logic [2*DW-1:0] shl_ext, shr_ext;
    logic            shift_big, div_zero, is_seq;
    logic [DW-1:0]   alu_res;
    logic            alu_c;

    assign sum_w     = {1'b0, op1} + {1'b0, op2};
    assign diff_w    = {1'b0, op1} - {1'b0, op2};
    assign shl_ext   = {{DW{1'b0}}, op1} << op2;
    assign shr_ext   = {op1, {DW{1'b0}}} >> op2;
    assign shift_big = ({1'b0, op2} >= (DW+1)'(DW));
    assign div_zero  = ((op == OP_DIV) || (op == OP_MOD)) && (op2 == '0);
    assign is_seq    = ((op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD)) && !div_zero;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD:  begin alu_res = sum_w[DW-1:0];  alu_c = sum_w[DW];  end
            OP_SUB:  begin alu_res = diff_w[DW-1:0]; alu_c = diff_w[DW]; end
            OP_XOR:  alu_res = op1 ^ op2;
            OP_OR:   alu_res = op1 | op2;
            OP_AND:  alu_res = op1 & op2;
            OP_NOR:  alu_res = ~(op1 | op2);
            OP_NAND: alu_res = ~(op1 & op2);
            OP_XNOR: alu_res = ~(op1 ^ op2);
            OP_SHL:  if (!shift_big) begin alu_res = shl_ext[DW-1:0];    alu_c = shl_ext[DW];   end
            OP_SHR:  if (!shift_big) begin alu_res = shr_ext[2*DW-1:DW]; alu_c = shr_ext[DW-1]; end
            OP_GT:   alu_res = {DW{op1 > op2}};
            OP_EQ:   alu_res = {DW{op1 == op2}};
            default: alu_res = '0;
        endcase
    end

    // MUL: {acc, a} shifts right with the multiplier in a (LSB first).
    // DIV/MOD: restoring division, quotient bits shift into a, remainder in acc.
    logic [DW:0]   mul_sum, div_trial, div_diff;
    logic          div_ge;
    logic [DW-1:0] mul_acc_n, mul_a_n, div_acc_n, div_a_n;

    assign mul_sum   = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : '0);
    assign mul_acc_n = mul_sum[DW:1];
    assign mul_a_n   = {mul_sum[0], a_q[DW-1:1]};
    assign div_trial = {acc_q, a_q[DW-1]};
    assign div_diff  = div_trial - {1'b0, b_q};
    assign div_ge    = (div_trial >= {1'b0, b_q});
    assign div_acc_n = div_ge ? div_diff[DW-1:0] : div_trial[DW-1:0];
    assign div_a_n   = {a_q[DW-2:0], div_ge};

    logic [DW-1:0] fin_res, fin_hi;
    always_comb begin
        fin_res = div_a_n;
        fin_hi  = div_acc_n;
        if (op_q == OP_MUL) begin
            fin_res = mul_a_n;
            fin_hi  = mul_acc_n;
        end else if (op_q == OP_MOD) begin
            fin_res = div_acc_n;
            fin_hi  = div_a_n;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        op_d        = op_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        z_d         = z_q;
        c_d         = c_q;
        n_d         = n_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = op1;
                    b_d   = op2;
                    op_d  = op;
                    cnt_d = '0;
                    acc_d = '0;
                    if (is_seq) begin
                        state_d = S_MULDIV;
                    end else begin
                        done_d = 1'b1;
                        if (div_zero) begin
                            result_d    = '1;
                            result_hi_d = op1;
                            err_d       = 1'b1;
                            c_d         = 1'b0;
                            z_d         = 1'b0;
                            n_d         = 1'b1;
                        end else if (op != OP_HALT) begin
                            result_d = alu_res;
                            c_d      = alu_c;
                            z_d      = (alu_res == '0);
                            n_d      = alu_res[DW-1];
                        end
                    end
                end
            end
            S_MULDIV: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    a_d   = mul_a_n;
                    acc_d = mul_acc_n;
                end else begin
                    a_d   = div_a_n;
                    acc_d = div_acc_n;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    result_d    = fin_res;
                    result_hi_d = fin_hi;
                    c_d         = (op_q == OP_MUL) && (fin_hi != '0);
                    z_d         = (fin_res == '0);
                    n_d         = fin_res[DW-1];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            n_q         <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            z_q         <= z_d;
            c_q         <= c_d;
            n_q         <= n_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_n    = n_q;
    assign busy      = (state_q == S_MULDIV);
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] value1 = '0, value2 = '0, addr1 = '0, addr2 = '0;
    logic [5:0] opcode = '0;
    logic [7:0] result, result_hi;
    logic       flag_z, flag_c, flag_n, busy, done, err, finish;

    alu_seq #(.DATA_WIDTH(8), .BUS_WIDTH(8), .OPCODE_WIDTH(6)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .value1(value1), .value2(value2), .addr1(addr1), .addr2(addr2),
        .opcode(opcode), .result(result), .result_hi(result_hi),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .busy(busy), .done(done), .err(err), .finish(finish)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [7:0] res, hi;
        logic       z, c, n, e;
        int         at;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d: got result=%0h expected no done", cyc, result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".cycle"}, cyc, e.at);
                chk({e.name, ".result"}, {24'd0, result}, {24'd0, e.res});
                chk({e.name, ".result_hi"}, {24'd0, result_hi}, {24'd0, e.hi});
                chk({e.name, ".zcn_err"}, {28'd0, flag_z, flag_c, flag_n, err}, {28'd0, e.z, e.c, e.n, e.e});
                $display("txn %s: result=%02h hi=%02h z=%b c=%b n=%b err=%b cycle=%0d",
                         e.name, result, result_hi, flag_z, flag_c, flag_n, err, cyc);
            end
        end
    end

    // Drive one start (held for a single cycle unless the caller drives again next cycle).
    task automatic issue(input string name, input logic [5:0] opc, input logic [7:0] v1, input logic [7:0] v2,
                         input logic [7:0] a1, input logic [7:0] a2, input bit push, input bit multi,
                         input logic [7:0] er, input logic [7:0] eh, input logic ez, input logic ec,
                         input logic en, input logic ee);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1; opcode = opc; value1 = v1; value2 = v2; addr1 = a1; addr2 = a2;
        if (push) begin
            e.name = name; e.res = er; e.hi = eh; e.z = ez; e.c = ec; e.n = en; e.e = ee;
            e.at = cyc + 1 + (multi ? 8 : 0);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset.result", {24'd0, result}, 32'd0);
        chk("reset.result_hi", {24'd0, result_hi}, 32'd0);
        chk("reset.flags", {27'd0, flag_z, flag_c, flag_n, busy, done}, 32'd0);
        chk("reset.err", {31'd0, err}, 32'd0);
        rstn = 1'b1;

        issue("add", 6'h00, 8'hF0, 8'h20, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0, 1, 0, 0);
        idle(1);

        issue("mul", 6'h30, 8'd25, 8'd12, 8'h00, 8'h00, 1, 1, 8'h2C, 8'h01, 0, 1, 0, 0);
        @(posedge clk); #1; start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk($sformatf("mul.busy_c%0d", i), {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("mul.busy_c9", {31'd0, busy}, 32'd0);

        issue("div", 6'h36, 8'd200, 8'hEE, 8'h00, 8'd7, 1, 1, 8'h1C, 8'h04, 0, 0, 0, 0);
        idle(10);
        issue("mod", 6'h3A, 8'd200, 8'hEE, 8'h00, 8'd7, 1, 1, 8'h04, 8'h1C, 0, 0, 0, 0);
        idle(10);

        issue("div0", 6'h34, 8'h55, 8'h00, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h55, 0, 0, 1, 1);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("div0.busy", {31'd0, busy}, 32'd0);
        idle(1);

        // ADD arriving while MUL is busy must be dropped and must not disturb it
        issue("mul2", 6'h30, 8'h0F, 8'h03, 8'h00, 8'h00, 1, 1, 8'h2D, 8'h00, 0, 0, 0, 0);
        idle(2);
        issue("add_ignored", 6'h00, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        idle(9);

        issue("mul_abort", 6'h30, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
        idle(4);
        rstn = 1'b0;
        #1;
        chk("abort.result", {24'd0, result}, 32'd0);
        chk("abort.result_hi", {24'd0, result_hi}, 32'd0);
        chk("abort.busy_done_err", {29'd0, busy, done, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(12);

        issue("shl1", 6'h20, 8'h81, 8'd1, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 0);
        idle(1);
        opcode = 6'h3F;
        #1;
        chk("finish.halt", {31'd0, finish}, 32'd1);
        opcode = 6'h3E;
        #1;
        chk("finish.other", {31'd0, finish}, 32'd0);
        issue("halt", 6'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h02, 8'h00, 0, 1, 0, 0);
        idle(1);
        issue("shl9", 6'h20, 8'h81, 8'd9, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        idle(1);

        // back-to-back single-cycle ops, one start every cycle
        issue("sub", 6'h04, 8'h10, 8'h20, 8'h00, 8'h00, 1, 0, 8'hF0, 8'h00, 0, 1, 1, 0);
        issue("gt", 6'h28, 8'd5, 8'd3, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 0, 0, 1, 0);
        issue("eq", 6'h2C, 8'd7, 8'd8, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        issue("shr1", 6'h24, 8'h81, 8'd1, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 0, 1, 0, 0);
        issue("xor_addr", 6'h0B, 8'h00, 8'h00, 8'hAA, 8'h0F, 1, 0, 8'hA5, 8'h00, 0, 0, 1, 0);
        issue("nand", 6'h18, 8'hFF, 8'hFF, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        idle(4);

        chk("scoreboard.empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no end of stimulus expected finish before 20000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing 6-bit opcode format: bits [1:0] select operand sources, bits [5:2] select the operation.
- Adds a start/busy/done handshake, sequential multiply, divide and modulo, a high-result register, and registered Z/C/N flags.
- Sits between the register-read stage and write-back. The controller holds in SCALC until done.

Parameters:
- DATA_WIDTH, 8: datapath width of operands, result and result_hi.
- BUS_WIDTH, 8: width of addr1/addr2. Zero-extended, or truncated to the low DATA_WIDTH bits, to form an operand.
- OPCODE_WIDTH, 6: opcode width. Fixed at 6 for this encoding.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only when busy=0.
- value1, value2  in  DATA_WIDTH  register operands.
- addr1, addr2  in  BUS_WIDTH  immediate/address operands.
- opcode  in  OPCODE_WIDTH  operation code.
- result  out  DATA_WIDTH  primary result (registered).
- result_hi  out  DATA_WIDTH  MUL high half, DIV remainder, MOD quotient (registered).
- flag_z, flag_c, flag_n  out  1  zero, carry/borrow, negative (MSB of result). Registered.
- busy  out  1  a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse when result and flags are updated.
- err  out  1  pulses with done on divide-by-zero.
- finish  out  1  combinational &opcode (HALT).

Behaviour:
- Reset: async on rstn low. Clears result, result_hi, all flags, busy, done, err, the counter and the internal state. State returns to IDLE. Reset mid-operation aborts with no done pulse.
- Operand select:
  - op1 = opcode[0] ? addr1 : value1
  - op2 = opcode[1] ? addr2 : value2
  - Both are latched into internal registers on an accepted start.
- Operation select, op = opcode[5:2]:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 NOR, 6 NAND, 7 XNOR
  - 8 SHL, 9 SHR, 10 GT (unsigned), 11 EQ, 12 MUL, 13 DIV, 14 MOD, 15 HALT
- Single-cycle ops (0–11, 15):
  - result is written on the edge after start. done=1 for exactly that following cycle.
  - result_hi is unchanged.
  - GT/EQ produce all-ones or all-zeros.
  - SHL/SHR with op2 >= DATA_WIDTH produce 0.
  - HALT leaves result and flags unchanged but still pulses done.
- Carry flag:
  - ADD: carry-out.
  - SUB: borrow (op1 < op2).
  - SHL: last bit shifted out (0 if the shift amount is 0 or >= DATA_WIDTH).
  - SHR: same rule.
  - MUL: set if result_hi != 0.
  - Cleared for all other ops.
- Z and N are computed from the new result on every done. They are unchanged on HALT.
- State machine:
  - IDLE: start with op 12–14 and divisor nonzero goes to MULDIV with busy=1 and counter=0.
  - MULDIV: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle. counter increments each cycle. On counter == DATA_WIDTH-1, write result/result_hi/flags, pulse done, drop busy and return to IDLE.
  - Latency: done is high in cycle DATA_WIDTH+1 counted from the start edge (9 for DATA_WIDTH=8).
- Divide-by-zero: DIV/MOD with op2 == 0 is detected at start. It completes as a single-cycle op:
  - result = all-ones, result_hi = op1.
  - err=1 together with done. C=0.
- start while busy=1 is ignored and the operation is not queued. Operands changing while busy have no effect.
- start in the same cycle as done is accepted only if busy=0 in that cycle. For single-cycle ops, back-to-back starts every cycle are legal.
- No arithmetic is signed. N is purely result[DATA_WIDTH-1].

Test Plan:
- Reset, then ADD with value1=8'hF0, value2=8'h20, opcode[1:0]=00 -> one cycle later done=1, result=8'h10, C=1, Z=0, N=0.
- MUL 8'd25 × 8'd12 -> busy for 8 cycles, done in cycle 9, result=8'h2C, result_hi=8'h01, C=1.
- DIV 8'd200 / addr2=8'd7 (opcode[1]=1) -> done in cycle 9, result=8'h1C, result_hi=8'h04. MOD on the same operands -> result=8'h04, result_hi=8'h1C.
- DIV 8'h55 / 0 -> done and err in cycle 1, result=8'hFF, result_hi=8'h55, busy never asserts.
- Start MUL, then pulse start with an ADD in cycle 3 -> ADD ignored, MUL result unchanged. Deassert rstn in cycle 5 of a second MUL -> all outputs 0 immediately, no done pulse.
- opcode=6'h3F -> finish=1 combinationally. With start -> done pulse, result and flags unchanged. SHL 8'h81 by 1 -> result=8'h02, C=1. SHL by 9 -> result=0, Z=1, C=0.
